// File: rtl/uart_tx_fifo_pkg.sv
// uart_pkg: shared types for the UART transmit FIFO front end.
// Exports: UART_DW, tx_fifo_state_t, clog2().
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE
  } tx_fifo_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer push side, status flags, uart_send handshake.
// master = environment (producer + uart_send), slave = uart_tx_fifo.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) ();

  localparam int LW = clog2(DEPTH) + 1;

  logic               wr_en;
  logic [UART_DW-1:0] wr_data;
  logic               full;
  logic               empty;
  logic [LW-1:0]      level;
  logic               ovf;
  logic               ack_err;
  logic               uart_en;
  logic [UART_DW-1:0] uart_din;
  logic               uart_tx_busy;

  modport master (
    output wr_en, wr_data, uart_tx_busy,
    input  full, empty, level, ovf,
    input  ack_err, uart_en, uart_din
  );

  modport slave (
    input  wr_en, wr_data, uart_tx_busy,
    output full, empty, level, ovf,
    output ack_err, uart_en, uart_din
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo_byte.sv
// sync_fifo_byte: power-of-two byte FIFO with registered level and sticky ovf.
// Ports: clk_i/rst_i, push_i/din_i, pop_i/dout_o, full_o, empty_o, level_o, ovf_o.
module sync_fifo_byte
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [UART_DW-1:0] din_i,
  input  logic               pop_i,
  output logic [UART_DW-1:0] dout_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [LW-1:0]      level_o,
  output logic               ovf_o
);

  logic [UART_DW-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [LW-1:0]      level_q;
  logic [LW-1:0]      level_d;
  logic               ovf_q;
  logic               do_push;
  logic               do_pop;

  // full comes from the registered level, so a push
  // while full is dropped even if a pop frees a slot.
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign ovf_o   = ovf_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop)
      level_d = level_q + LW'(1);
    else if (do_pop && !do_push)
      level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_i && full_o)
        ovf_q <= 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push)
      mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffers pushed bytes and launches them one at a time to uart_send.
// Ports: sys_clk, sys_rst (sync, active-high), bus (uart_tx_fifo_if.slave).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  uart_tx_fifo_if.slave    bus
);

  localparam int LW = clog2(DEPTH) + 1;

  logic [UART_DW-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LW-1:0]      fifo_level;
  logic               fifo_ovf;
  logic               pop;

  tx_fifo_state_t     state_q;
  logic [7:0]         timer_q;
  logic               uart_en_q;
  logic [UART_DW-1:0] din_q;
  logic               ack_err_q;

  assign pop = (state_q == IDLE) && !fifo_empty && !bus.uart_tx_busy;

  sync_fifo_byte #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .push_i  (bus.wr_en),
    .din_i   (bus.wr_data),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level),
    .ovf_o   (fifo_ovf)
  );

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.level    = fifo_level;
  assign bus.ovf      = fifo_ovf;
  assign bus.ack_err  = ack_err_q;
  assign bus.uart_en  = uart_en_q;
  assign bus.uart_din = din_q;

  // A launch that never sees busy rise is counted as
  // consumed; the byte is not retried.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      uart_en_q <= 1'b0;
      din_q     <= '0;
      ack_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          uart_en_q <= pop;
          if (pop) begin
            din_q   <= head;
            timer_q <= '0;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          uart_en_q <= 1'b0;
          if (bus.uart_tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == 8'(ACK_TIMEOUT - 1)) begin
            ack_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        WAIT_DONE: begin
          uart_en_q <= 1'b0;
          if (!bus.uart_tx_busy)
            state_q <= IDLE;
        end
        default: begin
          uart_en_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed + random pushes against a queue model
// of the FIFO and a behavioural uart_send busy model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH       = 16;
  localparam int ACK_TIMEOUT = 4;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  always #5 sys_clk = ~sys_clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model state
  logic [7:0] exp_q [$];
  logic [7:0] rx_q [$];
  logic       movf = 1'b0;
  logic       busy = 1'b0;
  logic       prev_en = 1'b0;
  int         busy_cnt = 0;
  int         mode = 0;   // 0 uart_send, 1 busy forced high, 2 busy tied low
  int         n_launch = 0;

  assign bus.uart_tx_busy = busy;

  // Inputs change at negedge+1, so here wr_en/wr_data/busy
  // still hold the values seen by the preceding posedge.
  always @(negedge sys_clk) begin : mon
    logic       full_prev;
    logic [7:0] b;
    if (sys_rst) begin
      exp_q.delete();
      movf = 1'b0;
    end else begin
      full_prev = (exp_q.size() == DEPTH);
      if (bus.uart_en) begin
        n_launch++;
        chk("launch_busy", busy, 0);
        chk("en_pulse", prev_en, 0);
        if (exp_q.size() == 0)
          chk("pop_empty", 1, 0);
        else begin
          b = exp_q.pop_front();
          chk("din_order", bus.uart_din, b);
        end
      end
      if (bus.wr_en) begin
        if (full_prev) movf = 1'b1;
        else exp_q.push_back(bus.wr_data);
      end
    end
    chk("level", bus.level, exp_q.size());
    chk("full", bus.full, exp_q.size() == DEPTH);
    chk("empty", bus.empty, exp_q.size() == 0);
    chk("ovf", bus.ovf, movf);
    prev_en = bus.uart_en;
    case (mode)
      1: begin busy = 1'b1; busy_cnt = 0; end
      2: begin busy = 1'b0; busy_cnt = 0; end
      default: begin
        if (busy_cnt > 0) busy_cnt--;
        if (bus.uart_en) begin
          busy_cnt = $urandom_range(3, 8);
          rx_q.push_back(bus.uart_din);
        end
        busy = (busy_cnt > 0);
      end
    endcase
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_launch(input string tag, input int budget);
    for (int i = 0; i < budget && !bus.uart_en; i++) tick();
    chk(tag, bus.uart_en, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && !(bus.empty && !busy && !bus.uart_en); i++)
      tick();
    chk("drain", bus.empty && !busy, 1);
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    string s;
    int    base;
    int    nl;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    tick();
    tick();
    sys_rst = 1'b0;
    tick();

    // reset defaults
    chk("rst_en", bus.uart_en, 0);
    chk("rst_din", bus.uart_din, 8'h00);
    chk("rst_full", bus.full, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_level", bus.level, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_ack", bus.ack_err, 0);

    // single byte latency
    push(8'h48);
    chk("lat_level1", bus.level, 1);
    chk("lat_en_n1", bus.uart_en, 0);
    tick();
    chk("lat_en_n2", bus.uart_en, 1);
    chk("lat_din", bus.uart_din, 8'h48);
    chk("lat_level0", bus.level, 0);
    tick();
    chk("lat_en_off", bus.uart_en, 0);
    drain();

    // burst through the uart_send model
    s = "Hello World!\n";
    rx_q.delete();
    for (int i = 0; i < s.len(); i++) push(s[i]);
    drain();
    chk("burst_cnt", rx_q.size(), 13);
    for (int i = 0; i < 13 && i < rx_q.size(); i++)
      chk("burst_rx", rx_q[i], s[i]);

    // overflow with busy held high
    mode = 1;
    tick();
    tick();
    base = rx_q.size();
    for (int i = 0; i < 18; i++) push(8'(8'h80 + i));
    chk("ovf_level", bus.level, 16);
    chk("ovf_full", bus.full, 1);
    chk("ovf_flag", bus.ovf, 1);

    // push at full in the launch cycle
    mode = 0;
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    tick();
    bus.wr_en   = 1'b0;
    chk("same_en", bus.uart_en, 1);
    chk("same_level", bus.level, 15);
    chk("same_ovf", bus.ovf, 1);
    drain();
    chk("ovf_sent", rx_q.size() - base, 16);
    for (int i = 0; i < 16 && base + i < rx_q.size(); i++)
      chk("ovf_rx", rx_q[base+i], 8'(8'h80 + i));

    // acknowledge timeout
    mode = 2;
    tick();
    push(8'hA5);
    wait_launch("ack_launch", 10);
    chk("ack_din", bus.uart_din, 8'hA5);
    chk("ack_pre", bus.ack_err, 0);
    tick();
    tick();
    tick();
    chk("ack_early", bus.ack_err, 0);
    tick();
    chk("ack_set", bus.ack_err, 1);
    mode = 0;
    push(8'h5A);
    wait_launch("ack_next", 10);
    chk("ack_next_din", bus.uart_din, 8'h5A);
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) push(8'($urandom));
      else tick();
    end
    drain();

    // reset in WAIT_DONE with five bytes queued
    for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
    for (int i = 0; i < 300 && !(bus.level == 5 && busy); i++) tick();
    chk("mid_reach", bus.level == 5 && busy, 1);
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("mid_level", bus.level, 0);
    chk("mid_empty", bus.empty, 1);
    chk("mid_en", bus.uart_en, 0);
    chk("mid_ovf", bus.ovf, 0);
    chk("mid_ack", bus.ack_err, 0);
    nl = n_launch;
    repeat (40) tick();
    chk("mid_quiet", n_launch - nl, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-buffering front end for `uart_send`. Producers push bytes with a single-cycle write strobe. The block stores them in a power-of-two FIFO and hands them one at a time to `uart_send` over the `uart_en` / `uart_din` / `uart_tx_busy` handshake. It sits directly upstream of `uart_send` and replaces ad-hoc "wait for not-busy, then strobe" logic in message generators and loopback paths.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `ACK_TIMEOUT`, 4: cycles to wait for `uart_tx_busy` to rise after a launch; range 2..255.
- `sys_clk`, in, 1: single clock, rising edge.
- `sys_rst`, in, 1: reset; one clock, synchronous, active-high.
- `wr_en`, in, 1: push `wr_data` this cycle.
- `wr_data`, in, 8: byte to push.
- `full`, out, 1: `level == DEPTH`.
- `empty`, out, 1: `level == 0`.
- `level`, out, log2(DEPTH)+1: bytes stored; does not count the byte in flight.
- `ovf`, out, 1: sticky; set when a push is dropped.
- `ack_err`, out, 1: sticky; set on an acknowledge timeout.
- `uart_en`, out, 1: one-cycle launch strobe to `uart_send`.
- `uart_din`, out, 8: byte to `uart_send`; held stable until the next launch.
- `uart_tx_busy`, in, 1: busy flag from `uart_send`.

## Operation
- **Storage:** circular buffer with `wr_ptr` and `rd_ptr`, each log2(DEPTH) bits, wrapping naturally. `level` is a registered counter.
- **Push:**
  - When `wr_en && !full`: write `mem[wr_ptr]`, increment `wr_ptr`.
  - When `wr_en && full`: drop the byte, leave pointers unchanged, set `ovf`.
  - `full` is the registered value, so a push while full is dropped even if a pop happens in the same cycle.
- **Pop:** occurs only from IDLE (see FSM).
- **Level update:**
  - Push and pop in the same cycle: `level` unchanged.
  - Push only: `level + 1`.
  - Pop only: `level - 1`.
- **FSM states:** IDLE, WAIT_ACK, WAIT_DONE.
  - **IDLE:**
    - If `!empty && !uart_tx_busy`: `uart_din <= mem[rd_ptr]`, `uart_en <= 1`, increment `rd_ptr`, clear the timer, go to WAIT_ACK.
    - Otherwise stay.
  - **WAIT_ACK:**
    - `uart_en <= 0`.
    - If `uart_tx_busy`: go to WAIT_DONE.
    - Otherwise increment the timer. When the timer reaches `ACK_TIMEOUT-1`, set `ack_err` and go to IDLE. The byte counts as consumed and is not retried.
  - **WAIT_DONE:** when `!uart_tx_busy`, go to IDLE.
- **Sticky flags:** `ovf` and `ack_err` are cleared only by `sys_rst`.
- **Reset mid-operation:** pointers, `level`, FSM and flags clear. Any byte in flight inside `uart_send` is not tracked; it finishes on its own.

## Timing
- **Reset values:**
  - `uart_en = 0`, `uart_din = 8'h00`
  - `full = 0`, `empty = 1`, `level = 0`
  - `ovf = 0`, `ack_err = 0`
  - FSM in IDLE
- **Latency:** a push at edge n into an empty FIFO, with the FSM idle and `uart_tx_busy` low, gives `uart_en` high during cycle n+2.
  - Edge n+1 sees `empty = 0`.
  - Edge n+1 registers the launch.
- **Launch shape:** `uart_en` is high for exactly one cycle. `uart_din` changes only on the edge that raises `uart_en`.
- **Back-to-back:** the next `uart_en` rises no earlier than 1 cycle after `uart_tx_busy` is sampled low in WAIT_DONE. With `uart_send` raising busy the cycle after `uart_en`, there is at most one strobe per frame.
- **Ready-to-launch boundary:** `uart_tx_busy` high in IDLE blocks the launch, which covers busy caused by another source.
- **Flag timing:** `ovf` and `ack_err` are set on the edge of the offending event.

## Structure
- **Shared package `uart_pkg`:**
  - `UART_DW = 8`
  - FSM state enum `tx_fifo_state_t` {IDLE, WAIT_ACK, WAIT_DONE}
  - `clog2` helper for pointer widths
- **Sub-module `sync_fifo_byte`:** memory, pointers, `level`, `full`, `empty`, `ovf`. Parameter `DEPTH`; ports push and pop.
- **Top level:** FSM, timer and launch register.

## Test plan
- **Reset defaults:** after reset, check all outputs. Then push `8'h48` once → `uart_en` is a 1-cycle pulse 2 cycles later with `uart_din = 8'h48`; `level` goes 0→1→0.
- **Burst through `uart_send` (`CLK_FREQ=16`, `UART_BPS=1`):** push the 13 bytes "Hello World!\n" on consecutive cycles → 13 launches in order. Each launch comes only after busy has fallen. The loopback receiver output matches byte for byte.
- **Overflow:** with `DEPTH = 16` and `uart_tx_busy` forced high, push 18 bytes → `level = 16`, `full = 1`, `ovf = 1`. After release, exactly the first 16 bytes are sent.
- **Push at full with same-cycle pop:** at `level = 16`, push in the same cycle as a launch → the byte is dropped, `ovf` is set, `level = 15`.
- **Acknowledge timeout:** tie `uart_tx_busy` low, push `8'hA5` → `uart_en` pulses, `ack_err` sets 4 cycles later, FSM returns to IDLE. A following byte launches normally.
- **Reset mid-burst:** assert `sys_rst` for 1 cycle while in WAIT_DONE with `level = 5` → `level = 0`, `empty = 1`, no further `uart_en`.
